// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux
// Purpose  : N-way registered stream multiplexer with valid/ready handshakes.
//            Arbitration is round-robin (RR_MODE=1) or fixed priority with the
//            lowest index winning (RR_MODE=0). Each accepted beat is stored,
//            together with the index of the source that supplied it, in a
//            single output register.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_data    - N_INPUTS packed channels, channel i at [i*WIDTH +: WIDTH]
//            in_valid   - per-channel valid
//            in_ready   - per-channel ready (one-hot or zero)
//            out_data   - registered data of the current output beat
//            out_sel    - registered index of the channel that supplied out_data
//            out_valid  - registered valid
//            out_ready  - consumer ready
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_mux #(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4,
  parameter int RR_MODE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_valid,
  output logic [N_INPUTS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_INPUTS)-1:0] out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SEL_W = $clog2(N_INPUTS);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             load_en;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic             xfer;

  // The register can take a new beat when it is empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Arbitration. Both searches walk from the far end toward the preferred
  // candidate so the last hit (the highest-priority one) is what remains.
  always_comb begin
    int               j;
    logic [SEL_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    cand      = '0;
    if (RR_MODE != 0) begin
      for (int k = N_INPUTS - 1; k >= 0; k--) begin
        j = int'(ptr_q) + k;
        if (j >= N_INPUTS) j = j - N_INPUTS;
        cand = SEL_W'(j);
        if (in_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      for (int k = N_INPUTS - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          win_found = 1'b1;
          win_idx   = SEL_W'(k);
        end
      end
    end
  end

  // Data mux driven by the winning index only.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (win_idx == SEL_W'(i)) win_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready goes only to the winner; other channels' valid never reaches it.
  generate
    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ready
      assign in_ready[g] = win_found && load_en && (win_idx == SEL_W'(g));
    end
  endgenerate

  assign xfer = win_found && load_en;

  // Next-state: output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_sel_d   = win_idx;
      if (RR_MODE != 0) begin
        ptr_d = (win_idx == SEL_W'(N_INPUTS - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if (out_ready) begin
      // Drain without refill; data and index are left as they were.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_mux
// Purpose  : Self-checking bench for rr_stream_mux. Three instances are used:
//            4-way round-robin, 4-way fixed priority and 3-way round-robin.
//            Expected beats are queued when stimulus is applied and compared
//            as the output register presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_mux;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int    n_checks = 0;
  int    n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-way round-robin
  logic [127:0] rr4_data;
  logic [3:0]   rr4_valid, rr4_ready;
  logic [31:0]  rr4_odata;
  logic [1:0]   rr4_osel;
  logic         rr4_ovalid, rr4_oready;
  // 4-way fixed priority
  logic [127:0] fp4_data;
  logic [3:0]   fp4_valid, fp4_ready;
  logic [31:0]  fp4_odata;
  logic [1:0]   fp4_osel;
  logic         fp4_ovalid, fp4_oready;
  // 3-way round-robin
  logic [95:0]  rr3_data;
  logic [2:0]   rr3_valid, rr3_ready;
  logic [31:0]  rr3_odata;
  logic [1:0]   rr3_osel;
  logic         rr3_ovalid, rr3_oready;

  rr_stream_mux #(.WIDTH(32), .N_INPUTS(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(rr4_data), .in_valid(rr4_valid),
    .in_ready(rr4_ready), .out_data(rr4_odata), .out_sel(rr4_osel),
    .out_valid(rr4_ovalid), .out_ready(rr4_oready));

  rr_stream_mux #(.WIDTH(32), .N_INPUTS(4), .RR_MODE(0)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(fp4_data), .in_valid(fp4_valid),
    .in_ready(fp4_ready), .out_data(fp4_odata), .out_sel(fp4_osel),
    .out_valid(fp4_ovalid), .out_ready(fp4_oready));

  rr_stream_mux #(.WIDTH(32), .N_INPUTS(3), .RR_MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(rr3_data), .in_valid(rr3_valid),
    .in_ready(rr3_ready), .out_data(rr3_odata), .out_sel(rr3_osel),
    .out_valid(rr3_ovalid), .out_ready(rr3_oready));

  task automatic idle_inputs();
    rr4_valid = '0; fp4_valid = '0; rr3_valid = '0;
    rr4_oready = 1'b0; fp4_oready = 1'b0; rr3_oready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rr4_data = '0; fp4_data = '0; rr3_data = '0;
    #2;
    n_checks++; if (rr4_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_rr4_valid got %b want 0", rr4_ovalid); end
    n_checks++; if (rr4_odata !== 32'h0) begin n_fail++; $display("FAIL reset_rr4_data got %h want 0", rr4_odata); end
    n_checks++; if (fp4_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_fp4_valid got %b want 0", fp4_ovalid); end
    n_checks++; if (rr3_osel !== 2'd0) begin n_fail++; $display("FAIL reset_rr3_sel got %0d want 0", rr3_osel); end
    n_checks++; if (rr4_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_rr4_ready got %b want 0000", rr4_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_traffic();
    apply_reset();
    for (int i = 0; i < 4; i++) rr4_data[i*32 +: 32] = 32'hA0 + i;
    rr4_valid = 4'b1111; rr4_oready = 1'b0;
    @(negedge clk);
    n_checks++; if (rr4_ovalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", rr4_ovalid); end
    #2 rst_n = 1'b0;
    rr4_valid = 4'b0000;
    #1;
    n_checks++; if (rr4_ovalid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", rr4_ovalid); end
    n_checks++; if (rr4_odata !== 32'h0) begin n_fail++; $display("FAIL rst_async_data got %h want 0", rr4_odata); end
    n_checks++; if (rr4_osel !== 2'd0) begin n_fail++; $display("FAIL rst_async_sel got %0d want 0", rr4_osel); end
    n_checks++; if (u_rr4.ptr_q !== 2'd0) begin n_fail++; $display("FAIL rst_async_ptr got %0d want 0", u_rr4.ptr_q); end
    @(negedge clk);
    rst_n = 1'b1;
    rr4_valid = 4'b1111; rr4_oready = 1'b1;
    sb.push_back('{sel: 2'd0, data: 32'hA0});
    @(negedge clk);
    rr4_valid = 4'b0000;
    n_checks++; if (rr4_ovalid !== 1'b1) begin n_fail++; $display("FAIL rst_first_valid got %b want 1", rr4_ovalid); end
    if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL rst_first_sb got empty want entry"); end
    else begin
      exp_b = sb.pop_front();
      n_checks++; if (rr4_osel !== exp_b.sel || rr4_odata !== exp_b.data) begin n_fail++; $display("FAIL rst_first_beat got %0d/%h want %0d/%h", rr4_osel, rr4_odata, exp_b.sel, exp_b.data); end
    end
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    for (int i = 0; i < 4; i++) rr4_data[i*32 +: 32] = 32'hA0 + i;
    rr4_valid = 4'b1111; rr4_oready = 1'b1;
    sb.push_back('{sel: 2'd0, data: 32'hA0});
    sb.push_back('{sel: 2'd1, data: 32'hA1});
    sb.push_back('{sel: 2'd2, data: 32'hA2});
    sb.push_back('{sel: 2'd3, data: 32'hA3});
    sb.push_back('{sel: 2'd0, data: 32'hA0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (rr4_ovalid !== 1'b1) begin n_fail++; $display("FAIL rr_valid cyc%0d got %b want 1", c, rr4_ovalid); end
      if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL rr_sb cyc%0d got empty", c); end
      else begin
        exp_b = sb.pop_front();
        n_checks++; if (rr4_osel !== exp_b.sel || rr4_odata !== exp_b.data) begin n_fail++; $display("FAIL rr_beat cyc%0d got %0d/%h want %0d/%h", c, rr4_osel, rr4_odata, exp_b.sel, exp_b.data); end
      end
    end
    rr4_valid = 4'b0000;
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 4; i++) rr4_data[i*32 +: 32] = 32'hA0 + i;
    rr4_valid = 4'b0001; rr4_oready = 1'b1;
    sb.push_back('{sel: 2'd0, data: 32'hA0});
    sb.push_back('{sel: 2'd1, data: 32'hA1});
    @(negedge clk);
    rr4_oready = 1'b0; rr4_valid = 4'b0110;
    exp_b = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (rr4_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready cyc%0d got %b want 0000", c, rr4_ready); end
      n_checks++; if (rr4_ovalid !== 1'b1 || rr4_osel !== exp_b.sel || rr4_odata !== exp_b.data) begin n_fail++; $display("FAIL stall_hold cyc%0d got %b/%0d/%h want 1/%0d/%h", c, rr4_ovalid, rr4_osel, rr4_odata, exp_b.sel, exp_b.data); end
      n_checks++; if (u_rr4.ptr_q !== 2'd1) begin n_fail++; $display("FAIL stall_ptr cyc%0d got %0d want 1", c, u_rr4.ptr_q); end
      @(negedge clk);
    end
    rr4_oready = 1'b1;
    #1;
    n_checks++; if (rr4_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release_ready got %b want 0010", rr4_ready); end
    @(negedge clk);
    rr4_valid = 4'b0000;
    exp_b = sb.pop_front();
    n_checks++; if (rr4_ovalid !== 1'b1 || rr4_osel !== exp_b.sel || rr4_odata !== exp_b.data) begin n_fail++; $display("FAIL stall_after got %b/%0d/%h want 1/%0d/%h", rr4_ovalid, rr4_osel, rr4_odata, exp_b.sel, exp_b.data); end
    n_checks++; if (u_rr4.ptr_q !== 2'd2) begin n_fail++; $display("FAIL stall_after_ptr got %0d want 2", u_rr4.ptr_q); end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    for (int i = 0; i < 4; i++) fp4_data[i*32 +: 32] = 32'hB0 + i;
    fp4_valid = 4'b1010; fp4_oready = 1'b1;
    for (int c = 0; c < 3; c++) sb.push_back('{sel: 2'd1, data: 32'hB1});
    sb.push_back('{sel: 2'd3, data: 32'hB3});
    #1;
    n_checks++; if (fp4_ready !== 4'b0010) begin n_fail++; $display("FAIL fp_ready got %b want 0010", fp4_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) fp4_valid = 4'b1000;
      if (c == 3) fp4_valid = 4'b0000;
      if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL fp_sb cyc%0d got empty", c); end
      else begin
        exp_b = sb.pop_front();
        n_checks++; if (fp4_ovalid !== 1'b1 || fp4_osel !== exp_b.sel || fp4_odata !== exp_b.data) begin n_fail++; $display("FAIL fp_beat cyc%0d got %b/%0d/%h want 1/%0d/%h", c, fp4_ovalid, fp4_osel, fp4_odata, exp_b.sel, exp_b.data); end
      end
    end
  endtask

  task automatic test_wrap3();
    apply_reset();
    for (int i = 0; i < 3; i++) rr3_data[i*32 +: 32] = 32'hC0 + i;
    rr3_valid = 3'b101; rr3_oready = 1'b1;
    sb.push_back('{sel: 2'd0, data: 32'hC0});
    sb.push_back('{sel: 2'd2, data: 32'hC2});
    sb.push_back('{sel: 2'd0, data: 32'hC0});
    sb.push_back('{sel: 2'd2, data: 32'hC2});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) rr3_valid = 3'b000;
      if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL wrap_sb cyc%0d got empty", c); end
      else begin
        exp_b = sb.pop_front();
        n_checks++; if (rr3_ovalid !== 1'b1 || rr3_osel !== exp_b.sel || rr3_odata !== exp_b.data) begin n_fail++; $display("FAIL wrap_beat cyc%0d got %b/%0d/%h want 1/%0d/%h", c, rr3_ovalid, rr3_osel, rr3_odata, exp_b.sel, exp_b.data); end
      end
      if (c == 1) begin
        n_checks++; if (u_rr3.ptr_q !== 2'd0) begin n_fail++; $display("FAIL wrap_ptr got %0d want 0", u_rr3.ptr_q); end
      end
    end
  endtask

  task automatic test_drain();
    apply_reset();
    rr4_data = '0;
    rr4_data[2*32 +: 32] = 32'h55;
    rr4_valid = 4'b0100; rr4_oready = 1'b1;
    sb.push_back('{sel: 2'd2, data: 32'h55});
    #1;
    n_checks++; if (rr4_ready !== 4'b0100) begin n_fail++; $display("FAIL drain_ready got %b want 0100", rr4_ready); end
    @(negedge clk);
    rr4_valid = 4'b0000;
    exp_b = sb.pop_front();
    n_checks++; if (rr4_ovalid !== 1'b1 || rr4_osel !== exp_b.sel || rr4_odata !== exp_b.data) begin n_fail++; $display("FAIL drain_beat got %b/%0d/%h want 1/%0d/%h", rr4_ovalid, rr4_osel, rr4_odata, exp_b.sel, exp_b.data); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (rr4_ovalid !== 1'b0 || rr4_osel !== 2'd2 || rr4_odata !== 32'h55) begin n_fail++; $display("FAIL drain_empty cyc%0d got %b/%0d/%h want 0/2/00000055", c, rr4_ovalid, rr4_osel, rr4_odata); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_traffic();
    test_rr_fairness();
    test_stall();
    test_fixed_priority();
    test_wrap3();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-way registered stream multiplexer with valid/ready handshakes and selectable arbitration (round-robin or fixed priority). It replaces the plain select-driven mux wherever several producers compete for one consumer, such as multiple request sources sharing a memory or writeback port. Each transfer carries its data and the index of the winning source through a single pipeline register.

## Interface
- WIDTH, default 32: data width of every channel.
- N_INPUTS, default 4: number of input channels. Legal values are 2 to 16.
- RR_MODE, default 1: selects arbitration. 1 means round-robin; 0 means fixed priority, where the lowest index wins.
- SEL_W, derived: $clog2(N_INPUTS). This is a localparam, not user-settable.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_data, input, N_INPUTS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N_INPUTS: per-channel valid.
- in_ready, output, N_INPUTS: per-channel ready. One-hot or all zero.
- out_data, output, WIDTH: registered data of the current output beat.
- out_sel, output, SEL_W: registered index of the channel that supplied out_data.
- out_valid, output, 1: registered valid.
- out_ready, input, 1: consumer ready.

## Operation
Reset values, applied asynchronously while rst_n = 0:
- out_valid = 0, out_data = 0, out_sel = 0.
- Round-robin pointer ptr = 0.
- Since out_valid = 0 during reset, in_ready may be nonzero only through the load condition; in_valid should be held low during reset.

Load condition:
- load_en = !out_valid || out_ready.

Arbitration (combinational, evaluated every cycle):
- RR_MODE = 1: the winner is the first index with in_valid set, searching ptr, ptr+1, …, N_INPUTS-1, 0, …, ptr-1 with modulo-N wrap.
- RR_MODE = 0: the winner is the lowest index with in_valid set. ptr is unused.
- If no in_valid bit is set, there is no winner.

Ready:
- in_ready[w] = load_en only when w is the winner.
- All other in_ready bits are 0.
- in_ready never depends on a non-winning channel's valid.

Transfer:
- A transfer on channel w happens when in_valid[w] && in_ready[w].
- At that clock edge: out_data <= in_data[w], out_sel <= w, out_valid <= 1.
- In RR mode, ptr <= (w+1) mod N_INPUTS. When w = N_INPUTS-1, ptr wraps to 0.

Output side:
- If out_valid && out_ready and no input transfers, out_valid <= 0. out_data and out_sel hold their values.
- If out_valid && !out_ready, the output register, ptr and all in_ready bits hold. This is the stall case.
- If out_ready = 1 and a new transfer occurs in the same cycle, the register is replaced. This gives back-to-back throughput of one beat per cycle with no bubble.

Fairness and stability:
- In RR mode, a continuously valid channel is granted within N_INPUTS transfers.
- ptr changes only on an input transfer, never on a stall or an idle cycle.
- A producer holding in_valid must keep in_data stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle: data accepted at edge k is visible on out_data after edge k.
- Throughput is 1 beat per cycle when out_ready is held high.
- There is a combinational path out_ready -> in_ready. There is no combinational path from in_valid/in_data to out_* or out_valid.
- When rst_n is asserted mid-transfer, the pending beat is dropped: out_valid goes to 0 immediately, without waiting for a clock edge.
- Reset is released synchronously to clk. The first transfer is possible on the first edge after release.

## Test plan
1. Reset during traffic, N=4, RR: drive rst_n=0 while out_valid=1 -> out_valid, out_data, out_sel and ptr are 0 before the next edge. After release, with in_valid=4'b1111, the first winner is ch0.
2. RR fairness, N=4, all in_valid=1, out_ready=1, in_data[i]=32'hA0+i -> out_sel sequence 0,1,2,3,0; out_data 0xA0..0xA3 then 0xA0; out_valid=1 every cycle.
3. Stall hold: out_ready=0 for 3 cycles with out_valid=1 and in_valid=4'b0110 -> in_ready=0, out_data/out_sel unchanged, ptr unchanged. When out_ready=1, the winner is the next channel at or after ptr.
4. Fixed priority, RR_MODE=0, in_valid=4'b1010 held -> ch1 wins every beat and ch3 is starved. Drop in_valid[1] -> ch3 wins next.
5. Pointer wrap with sparse valid, N=3, in_valid=3'b101: after ch2 transfers, ptr=0 -> next winner is ch0, then ch2.
6. Drain with no new input: single beat on ch2 (data 0x55), out_ready=1 with no further valid -> out_valid=1 for exactly one cycle with out_sel=2, then 0; out_data stays 0x55.
